// File: rtl/dsp_pkg.sv
// Shared DSP types and helpers for the FFT front end: feeder FSM states,
// the Q1.15 unity constant and a saturating arithmetic right shift.
package dsp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_READY,
    STREAM,
    WAIT_DONE
  } feeder_state_t;

  localparam logic signed [15:0] ONE_Q15 = 16'sh7FFF;
  localparam int unsigned        SAT_W   = 64;

  // Arithmetic shift right by 'shift', then clamp to a signed 'width'-bit range.
  function automatic logic signed [SAT_W-1:0] sat_shift(
    input logic signed [SAT_W-1:0] value,
    input int unsigned             shift,
    input int unsigned             width
  );
    logic signed [SAT_W-1:0] shifted;
    logic signed [SAT_W-1:0] max_v;
    logic signed [SAT_W-1:0] min_v;
    shifted = value >>> shift;
    max_v   = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v   = -(64'sd1 <<< (width - 1));
    if (shifted > max_v) begin
      return max_v;
    end else if (shifted < min_v) begin
      return min_v;
    end
    return shifted;
  endfunction

endpackage

// File: rtl/window_mult.sv
// Combinational window multiply: sample * Q1.(COEF_WIDTH-1) coefficient,
// rescaled back to DATA_WIDTH with saturation.
module window_mult
  import dsp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned COEF_WIDTH = 16
) (
  input  logic signed [DATA_WIDTH-1:0] sample,
  input  logic signed [COEF_WIDTH-1:0] coef,
  output logic signed [DATA_WIDTH-1:0] result_c
);

  localparam int unsigned PROD_W = DATA_WIDTH + COEF_WIDTH;

  logic signed [PROD_W-1:0] prod;
  logic signed [SAT_W-1:0]  sat;

  always_comb begin
    prod     = PROD_W'(sample) * PROD_W'(coef);
    sat      = sat_shift(SAT_W'(prod), COEF_WIDTH - 1, DATA_WIDTH);
    result_c = DATA_WIDTH'(sat);
  end

endmodule

// File: rtl/fft_frame_feeder.sv
// Frames a complex sample stream into N-sample ping-pong banks, windows each
// sample on readout and streams frames into the FFT, one frame per fft_done.
module fft_frame_feeder
  import dsp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned COEF_WIDTH = 16,
  parameter int unsigned N          = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic signed [DATA_WIDTH-1:0] s_real,
  input  logic signed [DATA_WIDTH-1:0] s_imag,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic                         win_wr_en,
  input  logic [$clog2(N)-1:0]         win_index,
  input  logic signed [COEF_WIDTH-1:0] win_value,
  output logic                         fft_start,
  output logic signed [DATA_WIDTH-1:0] fft_din_real,
  output logic signed [DATA_WIDTH-1:0] fft_din_imag,
  output logic                         fft_din_valid,
  input  logic                         fft_din_ready,
  input  logic                         fft_done,
  output logic                         overflow,
  output logic [15:0]                  frames_sent
);

  localparam int unsigned IDX_W = $clog2(N);
  localparam int unsigned CNT_W = IDX_W + 1;

  feeder_state_t               state_q, state_d;
  logic [1:0]                  bank_full_q, bank_full_d;
  logic                        wr_bank_q, wr_bank_d;
  logic [IDX_W-1:0]            wr_idx_q, wr_idx_d;
  logic                        rd_bank_q, rd_bank_d;
  logic [CNT_W-1:0]            rd_cnt_q, rd_cnt_d;
  logic                        fft_start_q, fft_start_d;
  logic                        fft_din_valid_q, fft_din_valid_d;
  logic signed [DATA_WIDTH-1:0] fft_din_real_q, fft_din_real_d;
  logic signed [DATA_WIDTH-1:0] fft_din_imag_q, fft_din_imag_d;
  logic                        overflow_q, overflow_d;
  logic [15:0]                 frames_sent_q, frames_sent_d;
  logic signed [COEF_WIDTH-1:0] coef_q [N];
  logic signed [COEF_WIDTH-1:0] coef_d [N];
  logic signed [DATA_WIDTH-1:0] mem_real_q [2][N];
  logic signed [DATA_WIDTH-1:0] mem_imag_q [2][N];

  logic                         wr_en_c;
  logic                         release_c;
  logic [IDX_W-1:0]             rd_idx_c;
  logic signed [DATA_WIDTH-1:0] win_real_c, win_imag_c;

  assign s_ready   = !bank_full_q[wr_bank_q];
  assign wr_en_c   = s_valid && s_ready;
  assign release_c = (state_q == WAIT_DONE) && fft_done;
  assign rd_idx_c  = rd_cnt_q[IDX_W-1:0];

  window_mult #(.DATA_WIDTH(DATA_WIDTH), .COEF_WIDTH(COEF_WIDTH)) u_win_real (
    .sample   (mem_real_q[rd_bank_q][rd_idx_c]),
    .coef     (coef_q[rd_idx_c]),
    .result_c (win_real_c)
  );

  window_mult #(.DATA_WIDTH(DATA_WIDTH), .COEF_WIDTH(COEF_WIDTH)) u_win_imag (
    .sample   (mem_imag_q[rd_bank_q][rd_idx_c]),
    .coef     (coef_q[rd_idx_c]),
    .result_c (win_imag_c)
  );

  // Write side: fill pointer, bank occupancy (set by writer, cleared by reader), overflow.
  always_comb begin
    bank_full_d = bank_full_q;
    wr_bank_d   = wr_bank_q;
    wr_idx_d    = wr_idx_q;
    overflow_d  = overflow_q || (s_valid && !s_ready);
    coef_d      = coef_q;
    if (wr_en_c) begin
      if (wr_idx_q == IDX_W'(N - 1)) begin
        bank_full_d[wr_bank_q] = 1'b1;
        wr_bank_d              = !wr_bank_q;
        wr_idx_d               = '0;
      end else begin
        wr_idx_d = wr_idx_q + IDX_W'(1);
      end
    end
    if (release_c) begin
      bank_full_d[rd_bank_q] = 1'b0;
    end
    if (win_wr_en) begin
      coef_d[win_index] = win_value;
    end
  end

  // Read FSM; rd_cnt counts samples already loaded into the output register.
  always_comb begin
    state_d         = state_q;
    rd_bank_d       = rd_bank_q;
    rd_cnt_d        = rd_cnt_q;
    fft_start_d     = 1'b0;
    fft_din_valid_d = fft_din_valid_q;
    fft_din_real_d  = fft_din_real_q;
    fft_din_imag_d  = fft_din_imag_q;
    frames_sent_d   = frames_sent_q;
    case (state_q)
      IDLE: begin
        if (bank_full_q[rd_bank_q]) begin
          state_d     = START;
          fft_start_d = 1'b1;
          rd_cnt_d    = '0;
        end
      end
      START: begin
        fft_din_real_d = win_real_c;
        fft_din_imag_d = win_imag_c;
        rd_cnt_d       = CNT_W'(1);
        state_d        = WAIT_READY;
      end
      WAIT_READY: begin
        if (fft_din_ready) begin
          fft_din_valid_d = 1'b1;
          state_d         = STREAM;
        end
      end
      STREAM: begin
        if (fft_din_ready) begin
          if (rd_cnt_q == CNT_W'(N)) begin
            fft_din_valid_d = 1'b0;
            frames_sent_d   = frames_sent_q + 16'd1;
            state_d         = WAIT_DONE;
          end else begin
            fft_din_real_d = win_real_c;
            fft_din_imag_d = win_imag_c;
            rd_cnt_d       = rd_cnt_q + CNT_W'(1);
          end
        end
      end
      WAIT_DONE: begin
        if (fft_done) begin
          rd_bank_d = !rd_bank_q;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      bank_full_q     <= '0;
      wr_bank_q       <= 1'b0;
      wr_idx_q        <= '0;
      rd_bank_q       <= 1'b0;
      rd_cnt_q        <= '0;
      fft_start_q     <= 1'b0;
      fft_din_valid_q <= 1'b0;
      fft_din_real_q  <= '0;
      fft_din_imag_q  <= '0;
      overflow_q      <= 1'b0;
      frames_sent_q   <= '0;
      for (int i = 0; i < int'(N); i++) begin
        coef_q[i] <= COEF_WIDTH'(ONE_Q15);
      end
    end else begin
      state_q         <= state_d;
      bank_full_q     <= bank_full_d;
      wr_bank_q       <= wr_bank_d;
      wr_idx_q        <= wr_idx_d;
      rd_bank_q       <= rd_bank_d;
      rd_cnt_q        <= rd_cnt_d;
      fft_start_q     <= fft_start_d;
      fft_din_valid_q <= fft_din_valid_d;
      fft_din_real_q  <= fft_din_real_d;
      fft_din_imag_q  <= fft_din_imag_d;
      overflow_q      <= overflow_d;
      frames_sent_q   <= frames_sent_d;
      coef_q          <= coef_d;
    end
  end

  // Sample store needs no reset: occupancy is tracked by bank_full.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem_real_q[wr_bank_q][wr_idx_q] <= s_real;
      mem_imag_q[wr_bank_q][wr_idx_q] <= s_imag;
    end
  end

  assign fft_start     = fft_start_q;
  assign fft_din_valid = fft_din_valid_q;
  assign fft_din_real  = fft_din_real_q;
  assign fft_din_imag  = fft_din_imag_q;
  assign overflow      = overflow_q;
  assign frames_sent   = frames_sent_q;

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Scoreboard bench for fft_frame_feeder: the driver pushes windowed expectations
// as samples are accepted, a negedge monitor pops them on every FFT transfer.
module tb_fft_frame_feeder;

  localparam int unsigned DW    = 16;
  localparam int unsigned CW    = 16;
  localparam int unsigned N     = 8;
  localparam int unsigned IDX_W = $clog2(N);

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic signed [DW-1:0] s_real = '0;
  logic signed [DW-1:0] s_imag = '0;
  logic                 s_valid = 1'b0;
  logic                 s_ready;
  logic                 win_wr_en = 1'b0;
  logic [IDX_W-1:0]     win_index = '0;
  logic signed [CW-1:0] win_value = '0;
  logic                 fft_start;
  logic signed [DW-1:0] fft_din_real;
  logic signed [DW-1:0] fft_din_imag;
  logic                 fft_din_valid;
  logic                 fft_din_ready = 1'b0;
  logic                 fft_done = 1'b0;
  logic                 overflow;
  logic [15:0]          frames_sent;

  fft_frame_feeder #(.DATA_WIDTH(DW), .COEF_WIDTH(CW), .N(N)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_real        (s_real),
    .s_imag        (s_imag),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .win_wr_en     (win_wr_en),
    .win_index     (win_index),
    .win_value     (win_value),
    .fft_start     (fft_start),
    .fft_din_real  (fft_din_real),
    .fft_din_imag  (fft_din_imag),
    .fft_din_valid (fft_din_valid),
    .fft_din_ready (fft_din_ready),
    .fft_done      (fft_done),
    .overflow      (overflow),
    .frames_sent   (frames_sent)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Driver-owned model state.
  int              m_filled = 0;
  int              m_part   = 0;
  bit              m_ovf    = 1'b0;
  int              coef_m [N];
  int              mode       = 0;
  int              done_delay = 0;
  // Monitor-owned model state.
  int              m_released = 0;
  int              m_xfer     = 0;
  int              m_frames   = 0;
  int              m_starts   = 0;
  int              m_done_req = 0;
  bit              m_armed    = 1'b0;
  bit              m_active   = 1'b0;
  bit              held_v     = 1'b0;
  int              held_re    = 0;
  int              held_im    = 0;
  int              exp_re_q [$];
  int              exp_im_q [$];

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Window reference: exact product, floor-divide by 2^15, clamp to int16.
  function automatic int win_ref(input int s, input int c);
    longint p;
    p = (longint'(s) * longint'(c)) >>> 15;
    if (p > 32767) p = 32767;
    if (p < -32768) p = -32768;
    return int'(p);
  endfunction

  function automatic bit model_ready();
    return (m_filled - m_released) < 2;
  endfunction

  // FFT model: start-relative ready pattern, done after a configurable delay.
  int f_cnt = -1, f_wait = -1, f_hold = 0, f_ack = 0;
  always begin
    @(posedge clk); #1;
    if (!rst_n) begin
      fft_din_ready = 1'b0; fft_done = 1'b0;
      f_cnt = -1; f_wait = -1; f_hold = 0; f_ack = 0;
    end else begin
      if (f_hold > 0) begin
        f_hold--;
        if (f_hold == 0) fft_done = 1'b0;
      end
      if (fft_start) begin
        f_cnt = 0; fft_din_ready = 1'b0;
      end else if (f_cnt >= 0) begin
        f_cnt++;
        case (mode)
          0:       fft_din_ready = (f_cnt >= 1);
          1:       fft_din_ready = (f_cnt > 5) && (f_cnt % 2 == 1);
          default: fft_din_ready = 1'($urandom_range(0, 1));
        endcase
      end
      if (m_done_req != f_ack) begin
        f_ack = m_done_req; f_cnt = -1; fft_din_ready = 1'b0; f_wait = done_delay;
      end
      if (f_wait >= 0) begin
        if (f_wait == 0) begin fft_done = 1'b1; f_hold = 2; end
        f_wait--;
      end
    end
  end

  // Monitor: reset values, start legality, held data, scoreboard pops, frame count.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_s_ready", s_ready, 1);
      check("rst_fft_start", fft_start, 0);
      check("rst_din_valid", fft_din_valid, 0);
      check("rst_din_real", fft_din_real, 0);
      check("rst_din_imag", fft_din_imag, 0);
      check("rst_overflow", overflow, 0);
      check("rst_frames_sent", frames_sent, 0);
      m_released = 0; m_xfer = 0; m_frames = 0; m_starts = 0; m_done_req = 0;
      m_armed = 1'b0; m_active = 1'b0; held_v = 1'b0;
      exp_re_q.delete(); exp_im_q.delete();
    end else begin
      check("frames_sent", frames_sent, m_frames & 16'hFFFF);
      if (fft_start) begin
        check("start_while_active", m_active, 0);
        check("start_with_full_bank", (m_filled - m_released) >= 1, 1);
        m_active = 1'b1;
        m_starts++;
      end
      if (held_v && fft_din_valid) begin
        check("held_real", $signed(fft_din_real), held_re);
        check("held_imag", $signed(fft_din_imag), held_im);
      end
      held_v = 1'b0;
      if (fft_din_valid && fft_din_ready) begin
        check("output_expected", exp_re_q.size() > 0, 1);
        if (exp_re_q.size() > 0) begin
          check("din_real", $signed(fft_din_real), exp_re_q.pop_front());
          check("din_imag", $signed(fft_din_imag), exp_im_q.pop_front());
        end
        m_xfer++;
        if (m_xfer == int'(N)) begin
          m_xfer = 0; m_frames++; m_armed = 1'b1; m_done_req++;
        end
      end else if (fft_din_valid) begin
        held_v = 1'b1; held_re = $signed(fft_din_real); held_im = $signed(fft_din_imag);
      end
      if (fft_done && m_armed) begin
        m_released++; m_armed = 1'b0; m_active = 1'b0;
      end
    end
  end

  // One source cycle: checks s_ready/overflow, drives, and books the expectation.
  task automatic drive_cycle(input bit v, input int re, input int im, input bit respect,
                             output bit accepted);
    @(posedge clk); #1;
    check("s_ready", s_ready, model_ready());
    check("overflow", overflow, m_ovf);
    win_wr_en = 1'b0;
    if (respect && !model_ready()) v = 1'b0;
    s_valid = v; s_real = DW'(re); s_imag = DW'(im);
    accepted = 1'b0;
    if (v) begin
      if (model_ready()) begin
        exp_re_q.push_back(win_ref(re, coef_m[m_part]));
        exp_im_q.push_back(win_ref(im, coef_m[m_part]));
        m_part++;
        if (m_part == int'(N)) begin m_part = 0; m_filled++; end
        accepted = 1'b1;
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  task automatic send(input int re, input int im);
    bit acc = 1'b0;
    for (int t = 0; t < 500 && !acc; t++) drive_cycle(1'b1, re, im, 1'b1, acc);
    check("send_timeout", acc, 1);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 0, 0, 1'b1, acc);
  endtask

  task automatic write_coef(input int idx, input int val);
    @(posedge clk); #1;
    check("s_ready", s_ready, model_ready());
    s_valid = 1'b0; win_wr_en = 1'b1;
    win_index = IDX_W'(idx); win_value = CW'(val);
    coef_m[idx] = win_ref(val, 32768) == val ? val : val;
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    for (int t = 0; t < 3000 && !done; t++) begin
      idle(1);
      done = (m_filled == m_released) && (m_part == 0) && !m_active && !m_armed;
    end
    check("drain_timeout", done, 1);
    check("leftover_expected", exp_re_q.size(), 0);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk); #1;
    rst_n = 1'b0; s_valid = 1'b0; win_wr_en = 1'b0;
    m_filled = 0; m_part = 0; m_ovf = 1'b0;
    for (int i = 0; i < int'(N); i++) coef_m[i] = 32'sh7FFF;
    repeat (cycles) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    bit hit;
    do_reset(3);

    // Half-scale window, ramp input.
    mode = 0; done_delay = 3;
    for (int i = 0; i < int'(N); i++) write_coef(i, 32'sh4000);
    for (int i = 0; i < int'(N); i++) send(100 * (i + 1), 0);
    wait_drain();

    // Saturation at the negative corner and near-unity scaling.
    for (int i = 0; i < int'(N); i++) write_coef(i, 32'sh7FFF);
    write_coef(0, -32768);
    send(-32768, -32768);
    send(100, -100);
    for (int i = 2; i < int'(N); i++) send($signed(16'($urandom)), $signed(16'($urandom)));
    wait_drain();

    // Stalled then toggling FFT ready.
    mode = 1; done_delay = 2;
    for (int i = 0; i < int'(N); i++) send($signed(16'($urandom)), $signed(16'($urandom)));
    wait_drain();

    // Random window, random ready, random source gaps.
    mode = 2;
    for (int i = 0; i < int'(N); i++) write_coef(i, $signed(16'($urandom)));
    for (int f = 0; f < 4; f++) begin
      done_delay = $urandom_range(0, 10);
      for (int k = 0; k < int'(N); k++) begin
        send($signed(16'($urandom)), $signed(16'($urandom)));
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
    end
    wait_drain();

    // Continuous source against a slow FFT: both banks fill, back-pressure.
    mode = 0; done_delay = 40;
    for (int i = 0; i < 3 * int'(N); i++) send($signed(16'($urandom)), $signed(16'($urandom)));
    wait_drain();

    // Overflow: offer blindly while both banks are full.
    done_delay = 30;
    for (int i = 0; i < 2 * int'(N); i++) send(i * 37 - 200, 500 - i * 11);
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 12345, -12345, 1'b0, hit);
    wait_drain();

    // Reset in the middle of streaming, then one clean frame.
    done_delay = 5;
    for (int i = 0; i < int'(N); i++) send($signed(16'($urandom)), $signed(16'($urandom)));
    idle(1);
    hit = 1'b0;
    for (int t = 0; t < 200 && !hit; t++) begin
      @(negedge clk); #1;
      hit = (m_xfer == 3);
    end
    check("reach_mid_stream", hit, 1);
    do_reset(3);
    idle(4);
    for (int i = 0; i < int'(N); i++) send(i * 1000 - 3000, 3000 - i * 1000);
    wait_drain();
    check("frames_after_reset", m_frames, 1);
    check("starts_vs_frames", m_starts, m_frames);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
